// File: rtl/sdi_localdata_pkg.sv
// sdi_localdata_pkg: shared mode codes, pattern header and FSM encoding for the SDI local data generator
package sdi_localdata_pkg;
  localparam logic [1:0] MODE_RAMP = 2'd0;
  localparam logic [1:0] MODE_CHAN = 2'd1;
  localparam logic [1:0] MODE_PAT = 2'd2;
  localparam logic [31:0] PAT_HDR = 32'hA5A5_0000;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
endpackage

// File: rtl/sdi_trig_edge.sv
// sdi_trig_edge: turns the asynchronous FA/EVR trigger into a one-cycle pulse, or passes it straight through
module sdi_trig_edge #(
  parameter bit TRIG_EDGE = 1
) (
  input  logic sdi_clk,
  input  logic Reset,
  input  logic Trigger,
  output logic trig
);
  if (TRIG_EDGE) begin : g_sync
    logic [2:0] syncReg;
    always_ff @(posedge sdi_clk)
      syncReg <= Reset ? '0 : {syncReg[1:0], Trigger};
    assign trig = syncReg[1] & ~syncReg[2];
  end else begin : g_bypass
    assign trig = Trigger;
  end
endmodule

// File: rtl/sdi_localdata_gen.sv
// sdi_localdata_gen: per-trigger frame generator emitting ramp, channel or pattern words over a valid/ready stream
module sdi_localdata_gen
  import sdi_localdata_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW = 32,
  parameter int LEN_W = 8,
  parameter bit TRIG_EDGE = 1,
  parameter int OVR_W = 16
) (
  input  logic               sdi_clk,
  input  logic               Reset,
  input  logic               Trigger,
  input  logic [LEN_W-1:0]   pkt_len,
  input  logic [1:0]         mode,
  input  logic [DW-1:0]      ramp_max,
  input  logic [NCH*DW-1:0]  ch_data,
  output logic [DW-1:0]      out_data,
  output logic [LEN_W-1:0]   out_idx,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               fa_evr_trig,
  output logic               ramp_rst,
  output logic               frame_done,
  output logic               busy,
  output logic               overrun,
  output logic [OVR_W-1:0]   overrun_cnt,
  input  logic               overrun_clr
);
  logic trig, hs, lastWord, ovrEvent;
  state_t state, nextState;
  logic [LEN_W-1:0] shLen;
  logic [1:0] shMode;
  logic [NCH*DW-1:0] shCh;
  logic [DW-1:0] base, baseNext;

  function automatic logic [DW-1:0] wordOf(logic [1:0] m, logic [DW-1:0] b, logic [LEN_W-1:0] i,
                                           logic [NCH*DW-1:0] ch);
    logic [DW-1:0] c;
    c = '0;
    for (int k = 0; k < NCH; k++) if (int'(i) == k) c = ch[k*DW +: DW];
    return m == MODE_RAMP ? b + DW'(i) : m == MODE_CHAN ? c : DW'({PAT_HDR[31:16], 16'(i)});
  endfunction

  sdi_trig_edge #(.TRIG_EDGE(TRIG_EDGE)) u_trig (
    .sdi_clk(sdi_clk),
    .Reset(Reset),
    .Trigger(Trigger),
    .trig(trig)
  );

  assign fa_evr_trig = trig;
  assign busy = state != IDLE;
  assign hs = out_valid && out_ready;
  assign lastWord = out_idx == shLen - LEN_W'(1);
  assign out_last = out_valid && lastWord;
  assign baseNext = base == ramp_max ? '0 : base + DW'(1);
  // a trigger that arrives while a frame is still in flight is lost
  assign ovrEvent = trig && state != IDLE;

  always_ff @(posedge sdi_clk)
    state <= Reset ? IDLE : nextState;

  always_comb begin
    nextState = state;
    nextState = state == IDLE ? (trig ? (pkt_len == '0 ? DONE : SEND) : IDLE) :
                state == SEND ? (hs && lastWord ? DONE : SEND) : IDLE;
  end

  always_ff @(posedge sdi_clk) begin
    if (Reset) begin
      shLen <= '0;
      shMode <= '0;
      shCh <= '0;
      base <= '0;
      out_data <= '0;
      out_idx <= '0;
      out_valid <= 1'b0;
      ramp_rst <= 1'b0;
      frame_done <= 1'b0;
      overrun <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      ramp_rst <= 1'b0;
      frame_done <= state == DONE;
      if (state == IDLE && trig) begin
        shLen <= pkt_len;
        shMode <= mode;
        shCh <= ch_data;
        base <= baseNext;
        ramp_rst <= base == ramp_max;
        out_idx <= '0;
        out_valid <= pkt_len != '0;
        out_data <= wordOf(mode, baseNext, '0, ch_data);
      end else if (state == SEND && hs) begin
        out_valid <= !lastWord;
        out_idx <= lastWord ? out_idx : out_idx + LEN_W'(1);
        out_data <= lastWord ? out_data : wordOf(shMode, base, out_idx + LEN_W'(1), shCh);
      end
      overrun <= overrun_clr ? ovrEvent : overrun | ovrEvent;
      overrun_cnt <= overrun_clr ? OVR_W'(ovrEvent) :
                     ovrEvent && ~&overrun_cnt ? overrun_cnt + OVR_W'(1) : overrun_cnt;
    end
  end
endmodule

// File: tb/tb_sdi_localdata_gen.sv
// tb_sdi_localdata_gen: directed checks of framing, modes, back-pressure, overrun and reset behaviour
module tb_sdi_localdata_gen;
  localparam int NCH = 4, DW = 32, LEN_W = 8, OVR_W = 16;
  logic sdi_clk = 0, Reset = 1, Trigger = 0, out_ready = 1, overrun_clr = 0;
  logic [LEN_W-1:0] pkt_len = '0;
  logic [1:0] mode = '0;
  logic [DW-1:0] ramp_max = '0;
  logic [NCH*DW-1:0] ch_data = '0;
  logic [DW-1:0] out_data;
  logic [LEN_W-1:0] out_idx;
  logic out_last, out_valid, fa_evr_trig, ramp_rst, frame_done, busy, overrun;
  logic [OVR_W-1:0] overrun_cnt;
  int nCmp = 0, nErr = 0;

  sdi_localdata_gen #(.NCH(NCH), .DW(DW), .LEN_W(LEN_W), .TRIG_EDGE(1), .OVR_W(OVR_W)) dut (
    .sdi_clk(sdi_clk), .Reset(Reset), .Trigger(Trigger), .pkt_len(pkt_len), .mode(mode),
    .ramp_max(ramp_max), .ch_data(ch_data), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .fa_evr_trig(fa_evr_trig),
    .ramp_rst(ramp_rst), .frame_done(frame_done), .busy(busy), .overrun(overrun),
    .overrun_cnt(overrun_cnt), .overrun_clr(overrun_clr)
  );

  always #5 sdi_clk = ~sdi_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge sdi_clk);
  endtask

  task automatic doReset();
    Reset = 1;
    tick();
    Reset = 0;
  endtask

  task automatic checkIdle(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_idx"}, out_idx, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_rr"}, ramp_rst, 0);
    chk({tag, "_ovr"}, {overrun, overrun_cnt}, 0);
  endtask

  // returns on the cycle in which the internal trigger pulse is visible
  task automatic fire();
    Trigger = 1;
    tick();
    chk("trig_lat1", fa_evr_trig, 0);
    Trigger = 0;
    tick();
    chk("trig_lat2", fa_evr_trig, 1);
  endtask

  task automatic waitDone(input string tag);
    logic seen;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      seen = frame_done;
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] bases[4];
    logic rrs[4];
    logic [DW-1:0] w6[6];
    int expIdx, hsCnt;
    logic seen;
    bases = '{32'd1, 32'd2, 32'd0, 32'd1};
    rrs = '{1'b0, 1'b0, 1'b1, 1'b0};
    w6 = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0};
    tick();
    doReset();
    checkIdle("rst");

    // channel mode, later input changes must not leak into the frame
    mode = 2'd1; pkt_len = 4; out_ready = 1;
    ch_data = {32'd4, 32'd3, 32'd2, 32'd1};
    fire();
    for (int i = 0; i < 4; i++) begin
      tick();
      ch_data = '1; mode = 2'd2;
      chk("ch_valid", out_valid, 1);
      chk("ch_data", out_data, i + 1);
      chk("ch_idx", out_idx, i);
      chk("ch_last", out_last, i == 3);
    end
    tick();
    chk("ch_tail_valid", out_valid, 0);
    chk("ch_tail_done", frame_done, 0);
    chk("ch_tail_busy", busy, 1);
    tick();
    chk("ch_done", frame_done, 1);
    chk("ch_idle", busy, 0);
    tick();
    chk("ch_done_pulse", frame_done, 0);

    // ramp mode wrap
    doReset();
    mode = 2'd0; ramp_max = 2; pkt_len = 2;
    for (int f = 0; f < 4; f++) begin
      fire();
      tick();
      chk("rmp_rr", ramp_rst, rrs[f]);
      chk("rmp_w0", out_data, bases[f]);
      chk("rmp_v0", out_valid, 1);
      tick();
      chk("rmp_rr_off", ramp_rst, 0);
      chk("rmp_w1", out_data, bases[f] + 1);
      chk("rmp_last", out_last, 1);
      tick();
      tick();
      chk("rmp_done", frame_done, 1);
    end

    // back-pressure in pattern mode
    doReset();
    mode = 2'd2; pkt_len = 3;
    fire();
    expIdx = 0; hsCnt = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      seen = frame_done;
      if (out_valid) begin
        chk("bp_data", out_data, 32'hA5A5_0000 | expIdx);
        chk("bp_idx", out_idx, expIdx);
        chk("bp_last", out_last, expIdx == 2);
        if (expIdx == 2) chk("pat_w2", out_data, 32'hA5A5_0002);
      end
      if (expIdx == 3) chk("bp_tail_valid", out_valid, 0);
      out_ready = (c % 3) == 0;
      if (out_valid && out_ready) begin
        expIdx++;
        hsCnt++;
      end
    end
    chk("bp_done", seen, 1);
    chk("bp_hs", hsCnt, 3);
    out_ready = 1;

    // overrun accounting
    doReset();
    mode = 2'd0; ramp_max = 100; pkt_len = 5; out_ready = 0;
    fire();
    tick();
    chk("ovr_w0", out_data, 1);
    fire();
    tick();
    chk("ovr_flag1", overrun, 1);
    chk("ovr_cnt1", overrun_cnt, 1);
    fire();
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    chk("ovr_clr_flag", overrun, 1);
    chk("ovr_clr_cnt", overrun_cnt, 1);
    chk("ovr_hold_data", out_data, 1);
    chk("ovr_hold_idx", out_idx, 0);
    out_ready = 1;
    waitDone("ovr_frame_done");
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    chk("ovr_cleared", {overrun, overrun_cnt}, 0);
    pkt_len = 1;
    fire();
    tick();
    chk("ovr_base_next", out_data, 2);
    chk("ovr_len1_last", out_last, 1);
    waitDone("ovr_len1_done");

    // empty frame
    doReset();
    pkt_len = 0;
    fire();
    tick();
    chk("len0_valid1", out_valid, 0);
    chk("len0_busy", busy, 1);
    chk("len0_early_done", frame_done, 0);
    tick();
    chk("len0_valid2", out_valid, 0);
    chk("len0_done", frame_done, 1);

    // frame longer than channel count
    doReset();
    mode = 2'd1; pkt_len = 6; ch_data = {32'd4, 32'd3, 32'd2, 32'd1};
    fire();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ch6_valid", out_valid, 1);
      chk("ch6_data", out_data, w6[i]);
      chk("ch6_last", out_last, i == 5);
    end
    waitDone("ch6_done");

    // reset mid-frame
    doReset();
    pkt_len = 4;
    fire();
    tick();
    chk("mid_w0", out_data, 1);
    tick();
    chk("mid_w1_idx", out_idx, 1);
    Reset = 1;
    tick();
    Reset = 0;
    checkIdle("mid_rst");
    tick();
    chk("mid_no_done1", frame_done, 0);
    tick();
    chk("mid_no_done2", frame_done, 0);
    fire();
    tick();
    chk("mid_restart_idx", out_idx, 0);
    chk("mid_restart_data", out_data, 1);
    chk("mid_restart_valid", out_valid, 1);
    waitDone("mid_restart_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
